// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 subset datapath.
// Optional performance counters are enabled with `define PERF_COUNTERS_EN.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [31:0] ir,
  output logic [1:0]  OrigWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  OrigPC,
  output logic        PCWrite,
  output logic [3:0]  ALUControl,
  output logic        OrigULA,
  output logic        RegWrite,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  localparam int          WAIT_W     = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [31:0] WAIT_LIMIT = 32'(MEM_WAIT_MAX);

  state_t            cur_state, nxt_state;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              ir_load;
  logic [1:0]        cause_nxt;
  logic              timeout_hit;
  logic [6:0]        opcode;
  logic [2:0]        funct3;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign state  = cur_state;

  function automatic logic is_legal(input logic [6:0] f7, input logic [2:0] f3,
                                    input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: ok = (f3 == 3'b010);
      OP_RTYPE: begin
        if ({f7[6], f7[4:0]} != 6'd0) ok = 1'b0;
        else if (f3 == 3'b000)        ok = 1'b1;
        else                          ok = !f7[5] && (f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111);
      end
      OP_ITYPE:  ok = (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111);
      OP_BRANCH: ok = (f3 == 3'b000);
      OP_JAL:    ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // bit30 only selects SUB for register-register ops; immediates are always ADD at 000
  function automatic logic [3:0] alu_sel(input logic [6:0] op, input logic [2:0] f3,
                                         input logic b30);
    logic [3:0] sel;
    sel = ALU_AND;
    case (op)
      OP_LOAD, OP_STORE: sel = ALU_ADD;
      OP_BRANCH:         sel = ALU_SUB;
      OP_RTYPE, OP_ITYPE: begin
        case (f3)
          3'b000:  sel = (op == OP_RTYPE && b30) ? ALU_SUB : ALU_ADD;
          3'b010:  sel = ALU_SLT;
          3'b110:  sel = ALU_OR;
          3'b111:  sel = ALU_AND;
          default: sel = ALU_AND;
        endcase
      end
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

  assign timeout_hit = (MEM_WAIT_MAX != 0) && !mem_ready &&
                       ((32'(wait_cnt) + 32'd1) >= WAIT_LIMIT);

  // State, IR, wait counter and sticky trap registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state  <= S_FETCH;
      ir         <= 32'd0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      wait_cnt   <= '0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
      if (ir_load) ir <= instr_in;
      if (nxt_state == S_TRAP && cur_state != S_TRAP) begin
        trap       <= 1'b1;
        trap_cause <= cause_nxt;
      end
    end
  end

  // Next-state, IR load and wait counter update
  always_comb begin
    nxt_state = cur_state;
    wait_nxt  = wait_cnt;
    ir_load   = 1'b0;
    cause_nxt = 2'd0;
    case (cur_state)
      S_FETCH: begin
        if (mem_ready) begin
          ir_load   = 1'b1;
          nxt_state = S_DECODE;
          wait_nxt  = '0;
        end else if (timeout_hit) begin
          nxt_state = S_TRAP;
          cause_nxt = 2'd2;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_legal(ir[31:25], funct3, opcode)) begin
          nxt_state = S_EXEC;
        end else begin
          nxt_state = S_TRAP;
          cause_nxt = 2'd1;
        end
      end
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          nxt_state = S_MEM;
          wait_nxt  = '0;
        end else if (opcode == OP_BRANCH || opcode == OP_JAL) begin
          nxt_state = S_FETCH;
          wait_nxt  = '0;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          nxt_state = (opcode == OP_LOAD) ? S_WB : S_FETCH;
          wait_nxt  = '0;
        end else if (timeout_hit) begin
          nxt_state = S_TRAP;
          cause_nxt = 2'd2;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_WB: begin
        nxt_state = S_FETCH;
        wait_nxt  = '0;
      end
      S_TRAP:  nxt_state = S_TRAP;
      default: nxt_state = S_FETCH;
    endcase
  end

  // Datapath selects and strobes decoded from state and IR
  always_comb begin
    OrigWriteData = 2'd0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    OrigPC        = 2'd0;
    PCWrite       = 1'b0;
    ALUControl    = 4'd0;
    OrigULA       = 1'b0;
    RegWrite      = 1'b0;
    if (cur_state == S_EXEC || cur_state == S_MEM || cur_state == S_WB) begin
      ALUControl = alu_sel(opcode, funct3, ir[30]);
      OrigULA    = (opcode == OP_LOAD || opcode == OP_STORE || opcode == OP_ITYPE);
    end else begin
      ALUControl = 4'd0;
    end
    case (cur_state)
      S_FETCH: MemRead = 1'b1;
      S_EXEC: begin
        if (opcode == OP_BRANCH) begin
          PCWrite = 1'b1;
          OrigPC  = zero ? 2'd1 : 2'd0;
        end else if (opcode == OP_JAL) begin
          RegWrite      = 1'b1;
          OrigWriteData = 2'd2;
          PCWrite       = 1'b1;
          OrigPC        = 2'd2;
        end else begin
          PCWrite = 1'b0;
        end
      end
      S_MEM: begin
        if (opcode == OP_LOAD) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = 1'b1;
          PCWrite  = mem_ready;
        end
      end
      S_WB: begin
        RegWrite      = 1'b1;
        PCWrite       = 1'b1;
        OrigWriteData = (opcode == OP_LOAD) ? 2'd0 : 2'd1;
      end
      default: PCWrite = 1'b0;
    endcase
    if (reset) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      PCWrite  = 1'b0;
    end else begin
      OrigPC = OrigPC;
    end
  end

`ifdef PERF_COUNTERS_EN
  // Free-running cycle and retired-instruction counters, wrapping naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (cur_state != S_TRAP) cycle_count <= cycle_count + CNT_WIDTH'(1);
      if (PCWrite) instret_count <= instret_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction/ready/zero stimulus compared every cycle against a behavioural model.
module tb_multicycle_control;
  localparam int WAITMAX = 4;
  localparam int CW      = 4;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_LW  = 32'h0000A283;
  localparam logic [31:0] I_BEQ = 32'h00000463;
  localparam logic [31:0] I_JAL = 32'h010000EF;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

  // instruction classes
  localparam int C_ILL = 0, C_LD = 1, C_ST = 2, C_R = 3, C_I = 4, C_BEQ = 5, C_JAL = 6;
  // phases, numbered as the state output reports them
  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_T = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_in = 32'd0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] ir;
  logic [1:0]  OrigWriteData, OrigPC, trap_cause;
  logic        MemRead, MemWrite, PCWrite, OrigULA, RegWrite, trap;
  logic [3:0]  ALUControl;
  logic [2:0]  state;
`ifdef PERF_COUNTERS_EN
  logic [CW-1:0] cycle_count, instret_count;
`endif

  multicycle_control #(.MEM_WAIT_MAX(WAITMAX), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready),
    .zero(zero), .ir(ir), .OrigWriteData(OrigWriteData), .MemRead(MemRead),
    .MemWrite(MemWrite), .OrigPC(OrigPC), .PCWrite(PCWrite), .ALUControl(ALUControl),
    .OrigULA(OrigULA), .RegWrite(RegWrite), .trap(trap), .trap_cause(trap_cause),
    .state(state)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'h03: return (f3 == 3'd2) ? C_LD : C_ILL;
      7'h23: return (f3 == 3'd2) ? C_ST : C_ILL;
      7'h33: begin
        if (w[31] || w[29:25] != 5'd0) return C_ILL;
        if (f3 == 3'd0) return C_R;
        if (!w[30] && (f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7)) return C_R;
        return C_ILL;
      end
      7'h13: return (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7) ? C_I : C_ILL;
      7'h63: return (f3 == 3'd0) ? C_BEQ : C_ILL;
      7'h6F: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // ALU op codes: AND=0 OR=1 ADD=2 SUB=6 SLT=7
  function automatic int alu_of(input logic [31:0] w);
    int c;
    c = cls(w);
    if (c == C_LD || c == C_ST) return 2;
    if (c == C_BEQ) return 6;
    if (c == C_R || c == C_I) begin
      case (w[14:12])
        3'd0: return (c == C_R && w[30]) ? 6 : 2;
        3'd2: return 7;
        3'd6: return 1;
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  typedef struct packed {
    logic       mr, mw, rw, pw, ula;
    logic [1:0] op, owd;
    logic [3:0] alu;
  } exp_t;

  function automatic exp_t expect_out(input int ph, input logic [31:0] w, input logic rdy,
                                      input logic z, input logic rst);
    exp_t e;
    int c;
    e = '0;
    c = cls(w);
    if (ph == P_E || ph == P_M || ph == P_W) begin
      e.alu = 4'(alu_of(w));
      e.ula = (c == C_LD || c == C_ST || c == C_I);
    end
    if (ph == P_F) e.mr = 1'b1;
    if (ph == P_E && c == C_BEQ) begin e.pw = 1'b1; e.op = z ? 2'd1 : 2'd0; end
    if (ph == P_E && c == C_JAL) begin e.pw = 1'b1; e.op = 2'd2; e.rw = 1'b1; e.owd = 2'd2; end
    if (ph == P_M && c == C_LD) e.mr = 1'b1;
    if (ph == P_M && c == C_ST) begin e.mw = 1'b1; e.pw = rdy; end
    if (ph == P_W) begin e.rw = 1'b1; e.pw = 1'b1; e.owd = (c == C_LD) ? 2'd0 : 2'd1; end
    if (rst) begin e.mr = 1'b0; e.mw = 1'b0; e.rw = 1'b0; e.pw = 1'b0; end
    return e;
  endfunction

  // behavioural model state
  int          m_ph = 0;
  logic [31:0] m_ir = 32'd0;
  logic        m_trap = 1'b0;
  int          m_cause = 0;
  int          m_stall = 0;
  int          m_cyc = 0;
  int          m_ret = 0;

  // Model advances one instruction phase per clock edge
  always @(posedge clock) begin
    exp_t e;
    int c;
    c = cls(m_ir);
    e = expect_out(m_ph, m_ir, mem_ready, zero, reset);
    if (reset) begin
      m_ph = P_F; m_ir = 32'd0; m_trap = 1'b0; m_cause = 0; m_stall = 0; m_cyc = 0; m_ret = 0;
    end else begin
      if (m_ph != P_T) m_cyc++;
      if (e.pw) m_ret++;
      if (m_ph == P_F || m_ph == P_M) begin
        if (mem_ready) begin
          m_stall = 0;
          if (m_ph == P_F) begin m_ir = instr_in; m_ph = P_D; end
          else m_ph = (c == C_LD) ? P_W : P_F;
        end else begin
          m_stall++;
          if (m_stall >= WAITMAX) begin m_ph = P_T; m_trap = 1'b1; m_cause = 2; end
        end
      end else if (m_ph == P_D) begin
        if (c == C_ILL) begin m_ph = P_T; m_trap = 1'b1; m_cause = 1; end
        else m_ph = P_E;
      end else if (m_ph == P_E) begin
        m_stall = 0;
        if (c == C_LD || c == C_ST) m_ph = P_M;
        else if (c == C_R || c == C_I) m_ph = P_W;
        else m_ph = P_F;
      end else if (m_ph == P_W) begin
        m_ph = P_F; m_stall = 0;
      end
    end
  end

  // Compare every DUT output against the model away from the active edge
  always @(negedge clock) begin
    exp_t e;
    if (chk_en) begin
      e = expect_out(m_ph, m_ir, mem_ready, zero, reset);
      chk("state", 32'(state), 32'(m_ph));
      chk("ir", ir, m_ir);
      chk("trap", 32'(trap), 32'(m_trap));
      chk("trap_cause", 32'(trap_cause), 32'(m_cause));
      chk("MemRead", 32'(MemRead), 32'(e.mr));
      chk("MemWrite", 32'(MemWrite), 32'(e.mw));
      chk("RegWrite", 32'(RegWrite), 32'(e.rw));
      chk("PCWrite", 32'(PCWrite), 32'(e.pw));
      chk("OrigPC", 32'(OrigPC), 32'(e.op));
      chk("OrigWriteData", 32'(OrigWriteData), 32'(e.owd));
      chk("ALUControl", 32'(ALUControl), 32'(e.alu));
      chk("OrigULA", 32'(OrigULA), 32'(e.ula));
      chk("rw_mw_exclusive", 32'(RegWrite & MemWrite), 32'd0);
`ifdef PERF_COUNTERS_EN
      chk("cycle_count", 32'(cycle_count), 32'(m_cyc % (1 << CW)));
      chk("instret_count", 32'(instret_count), 32'(m_ret % (1 << CW)));
`endif
    end
  end

  task automatic cyc(input logic r, input logic [31:0] ins, input logic rdy, input logic z);
    @(posedge clock);
    #1;
    reset = r; instr_in = ins; mem_ready = rdy; zero = z;
    @(negedge clock);
  endtask

  function automatic logic [2:0] pick_f3();
    case ($urandom_range(0, 3))
      0: return 3'd0;
      1: return 3'd2;
      2: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f;
    r = $urandom;
    f = pick_f3();
    case ($urandom_range(0, 7))
      0: return {r[31:15], 3'b010, r[11:7], 7'h03};
      1: return {r[31:15], 3'b010, r[11:7], 7'h23};
      2: return {1'b0, (f == 3'd0) ? r[30] : 1'b0, 5'd0, r[24:15], f, r[11:7], 7'h33};
      3: return {r[31:15], f, r[11:7], 7'h13};
      4: return {r[31:15], 3'b000, r[11:7], 7'h63};
      5: return {r[31:7], 7'h6F};
      6: return {r[31:7], 7'h33};
      default: return r;
    endcase
  endfunction

  initial begin
    // reset state, strobes forced low while reset is high
    cyc(1'b1, 32'd0, 1'b1, 1'b0);
    chk_en = 1'b1;
    chk("lit_rst_state", 32'(state), 32'd0);
    chk("lit_rst_ir", ir, 32'd0);
    chk("lit_rst_trap", 32'(trap), 32'd0);
    chk("lit_rst_memread", 32'(MemRead), 32'd0);

    // add: 0,1,2,4 then back to 0
    cyc(1'b0, I_ADD, 1'b1, 1'b0); chk("lit_add_fetch", 32'(state), 32'd0);
    cyc(1'b0, I_ADD, 1'b1, 1'b0); chk("lit_add_decode", 32'(state), 32'd1);
    chk("lit_add_ir", ir, I_ADD);
    cyc(1'b0, I_ADD, 1'b1, 1'b0); chk("lit_add_exec", 32'(state), 32'd2);
    chk("lit_add_alu", 32'(ALUControl), 32'd2);
    cyc(1'b0, I_ADD, 1'b1, 1'b0); chk("lit_add_wb", 32'(state), 32'd4);
    chk("lit_add_wb_strobes", {29'd0, RegWrite, OrigWriteData}, 32'd5);
    chk("lit_add_wb_pcw", 32'(PCWrite), 32'd1);
    cyc(1'b0, I_SUB, 1'b1, 1'b0); chk("lit_add_done", 32'(state), 32'd0);

    // sub
    cyc(1'b0, I_SUB, 1'b1, 1'b0);
    cyc(1'b0, I_SUB, 1'b1, 1'b0); chk("lit_sub_alu", 32'(ALUControl), 32'd6);
    cyc(1'b0, I_SUB, 1'b1, 1'b0);

    // lw with three stalled MEM cycles: 8 cycles total
    cyc(1'b0, I_LW, 1'b1, 1'b0); chk("lit_lw_fetch", 32'(state), 32'd0);
    cyc(1'b0, I_LW, 1'b1, 1'b0);
    cyc(1'b0, I_LW, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, I_LW, (k == 3), 1'b0);
      chk("lit_lw_mem_state", 32'(state), 32'd3);
      chk("lit_lw_memread", 32'(MemRead), 32'd1);
    end
    cyc(1'b0, I_BEQ, 1'b1, 1'b0); chk("lit_lw_wb", {29'd0, state}, 32'd4);
    chk("lit_lw_owd", 32'(OrigWriteData), 32'd0);

    // beq taken / not taken, then jal
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, I_BEQ, 1'b1, 1'b0); chk("lit_beq_fetch", 32'(state), 32'd0);
      cyc(1'b0, I_BEQ, 1'b1, 1'b0);
      cyc(1'b0, I_BEQ, 1'b1, (k == 0));
      chk("lit_beq_origpc", 32'(OrigPC), (k == 0) ? 32'd1 : 32'd0);
      chk("lit_beq_pcw", 32'(PCWrite), 32'd1);
    end
    cyc(1'b0, I_JAL, 1'b1, 1'b0); chk("lit_jal_fetch", 32'(state), 32'd0);
    cyc(1'b0, I_JAL, 1'b1, 1'b0);
    cyc(1'b0, I_JAL, 1'b1, 1'b0);
    chk("lit_jal_exec", {26'd0, OrigPC, RegWrite, 1'b0, OrigWriteData}, 32'h2A);

    // illegal instruction traps and sticks
    cyc(1'b0, I_BAD, 1'b1, 1'b0);
    cyc(1'b0, I_BAD, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, I_BAD, 1'b1, 1'b1);
      chk("lit_ill_trap", {29'd0, trap, trap_cause}, 32'd5);
      chk("lit_ill_strobes", {28'd0, MemRead, MemWrite, RegWrite, PCWrite}, 32'd0);
    end
    chk("lit_ill_state", 32'(state), 32'd5);

    // fetch timeout after four wait cycles
    cyc(1'b1, I_ADD, 1'b0, 1'b0);
    cyc(1'b0, I_ADD, 1'b0, 1'b0);
    chk("lit_rst_exit_state", 32'(state), 32'd0);
    chk("lit_rst_exit_trap", 32'(trap), 32'd0);
    for (int k = 0; k < 3; k++) cyc(1'b0, I_ADD, 1'b0, 1'b0);
    cyc(1'b0, I_ADD, 1'b0, 1'b0);
    chk("lit_to_state", 32'(state), 32'd5);
    chk("lit_to_cause", 32'(trap_cause), 32'd2);

    // ready on the limit cycle wins
    cyc(1'b1, I_ADD, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, I_ADD, 1'b0, 1'b0);
    cyc(1'b0, I_ADD, 1'b1, 1'b0);
    cyc(1'b0, I_ADD, 1'b1, 1'b0);
    chk("lit_limit_ready_state", 32'(state), 32'd1);
    chk("lit_limit_ready_trap", 32'(trap), 32'd0);

`ifdef PERF_COUNTERS_EN
    // 20 back-to-back adds: 80 cycles, counters wrap at 16
    cyc(1'b1, I_ADD, 1'b1, 1'b0);
    for (int k = 0; k < 81; k++) cyc(1'b0, I_ADD, 1'b1, 1'b0);
    chk("lit_perf_instret", 32'(instret_count), 32'd4);
    chk("lit_perf_cycles", 32'(cycle_count), 32'd0);
`endif

    // randomized traffic, reset used to leave TRAP
    cyc(1'b1, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      cyc(((m_ph == P_T) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 399) == 0),
          rand_instr(), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the RV32 subset datapath: LOAD, STORE, R-type, I-type ALU, BEQ and JAL.
- Fetches the instruction over a ready-handshaked memory port and latches it into an internal IR.
- Steps FETCH/DECODE/EXEC/MEM/WB, driving the same select and strobe encodings as the single-cycle control decoder.
- Sits between instruction/data memory and the register file/ALU/PC datapath.
- Traps on illegal encodings and on memory timeout.

Parameters:
MEM_WAIT_MAX, 16, max wait cycles for mem_ready in FETCH/MEM before timeout trap; 0 disables the timeout.
CNT_WIDTH, 32, width of the optional performance counters.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
instr_in  in  32  memory read data, sampled in FETCH when mem_ready=1
mem_ready  in  1  memory completes the current read/write this cycle
zero  in  1  ALU zero flag, sampled in EXEC for BEQ
ir  out  32  latched instruction to datapath/immediate gen
OrigWriteData  out  2  0=MEM, 1=ALU, 2=PC4
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
OrigPC  out  2  0=PC4, 1=PCBEQ, 2=PCIMM
PCWrite  out  1  PC load strobe, one cycle per retired instruction
ALUControl  out  4  AND=0, OR=1, ADD=2, SUB=6, SLT=7
OrigULA  out  1  0=REG, 1=IMM
RegWrite  out  1  register file write strobe
trap  out  1  sticky trap flag
trap_cause  out  2  0=none, 1=illegal instruction, 2=memory timeout
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5

Behaviour:
- Reset (sampled high at a clock edge):
  - state=FETCH, ir=0, trap=0, trap_cause=0, wait counter=0.
  - While reset is high, all strobes (MemRead, MemWrite, RegWrite, PCWrite) are forced 0.
  - Reset beats every other event, including mid-MEM and TRAP.
- Outputs decode combinationally from registered state plus ir. Selects not listed for a state drive 0.

- FETCH:
  - MemRead=1.
  - On mem_ready: ir<=instr_in, go to DECODE.
  - Else hold and increment the wait counter.
- DECODE:
  - Check opcode/funct3/funct7[30].
  - Illegal -> TRAP, cause=1.
  - Otherwise -> EXEC.
- Legal set:
  - LOAD funct3=010.
  - STORE funct3=010.
  - R-type: funct3 000 with bit30 0 or 1, funct3 010/110/111 with bit30=0; all other funct7 bits must be 0.
  - I-type: funct3 000/010/110/111.
  - BRANCH funct3=000 (BEQ).
  - JAL (any).
- EXEC:
  - LOAD/STORE: ALUControl=ADD, OrigULA=IMM, then -> MEM.
  - R: OrigULA=REG, ALUControl from funct3/bit30 (000/0=ADD, 000/1=SUB, 010=SLT, 110=OR, 111=AND), then -> WB.
  - I: same mapping with OrigULA=IMM; bit30 is ignored and 000 is always ADD. Then -> WB.
  - BEQ: ALUControl=SUB, OrigULA=REG, PCWrite=1, OrigPC = zero ? PCBEQ : PC4, then -> FETCH.
  - JAL: RegWrite=1, OrigWriteData=PC4, PCWrite=1, OrigPC=PCIMM, then -> FETCH.
- MEM:
  - ALUControl=ADD and OrigULA=IMM are held.
  - LOAD: MemRead=1; on mem_ready -> WB.
  - STORE: MemWrite=1; on mem_ready, PCWrite=1, OrigPC=PC4, -> FETCH.
  - Strobes stay asserted until mem_ready.
- WB:
  - RegWrite=1, PCWrite=1, OrigPC=PC4, then -> FETCH.
  - OrigWriteData = MEM for LOAD, ALU for R/I.
  - ALU selects are held from EXEC.
- Cycle counts (mem_ready immediate): R/I=4, LOAD=5, STORE=4, BEQ=3, JAL=3.
- Wait counter:
  - Clears on entry to FETCH/MEM and on mem_ready.
  - Counter reaching MEM_WAIT_MAX with mem_ready=0 -> TRAP, cause=2, strobes drop next cycle.
  - mem_ready in the same cycle as the limit: ready wins, no trap.
- TRAP:
  - All strobes 0, ir held.
  - trap=1 and trap_cause stick; only reset exits.
- PCWrite is never asserted twice for one instruction.
- RegWrite and MemWrite are never both asserted.

Optional Feature:
PERF_COUNTERS_EN
- Defined:
  - Adds outputs cycle_count[CNT_WIDTH] and instret_count[CNT_WIDTH], both reset to 0.
  - cycle_count increments every non-reset cycle while not in TRAP.
  - instret_count increments on each PCWrite pulse.
  - Both wrap modulo 2^CNT_WIDTH.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then instr_in=0x002081B3 (add x3,x1,x2) with mem_ready=1 -> states 0,1,2,4,0; ALUControl=2 in EXEC; RegWrite=1, OrigWriteData=1, PCWrite=1 in WB; 4 cycles.
- 0x402081B3 (sub) -> ALUControl=6; 0x0000A283 (lw x5,0(x1)) with mem_ready low 3 cycles in MEM -> MemRead held 4 cycles, then WB with OrigWriteData=0; 8 cycles total.
- 0x00000463 (beq) with zero=1 -> OrigPC=1, PCWrite=1 in EXEC; repeat with zero=0 -> OrigPC=0; JAL 0x010000EF -> OrigPC=2, RegWrite=1, OrigWriteData=2 in EXEC.
- instr_in=0xFFFFFFFF -> DECODE->TRAP, trap=1, cause=1, all strobes 0 for 20 cycles; assert reset -> state=0, trap=0.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in FETCH -> TRAP cause=2 after 4 wait cycles; mem_ready=1 exactly on the 4th cycle -> no trap, DECODE.
- PERF_COUNTERS_EN with CNT_WIDTH=4: 20 back-to-back add instructions -> instret_count wraps to 4, cycle_count=80 mod 16=0.
